// File: rtl/io_strobe_seq.sv
// io_strobe_seq: sequences one CPU I/O request into setup/strobe/hold phases
// on the inputs of a 3-to-8 chip-select decoder. Every output is a flop.
module io_strobe_seq #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned WIN_LSB    = 11,
  parameter int unsigned WIN_BASE   = 'h0B,
  parameter int unsigned SEL_LSB    = 8,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              ack,
  output logic              miss,
  output logic [2:0]        dec_a,
  output logic              dec_g1,
  output logic              dec_g2a_n,
  output logic              dec_g2b_n,
  output logic              rd_n,
  output logic              wr_n
);

  localparam int unsigned WIN_W = ADDR_W - WIN_LSB;
  localparam int unsigned CNT_W = 4;

  // Phase counter reload values (N-1); a zero-length hold is never loaded.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = (HOLD_CYC == 0) ? '0 : CNT_W'(HOLD_CYC - 1);
  localparam bit               HOLD_EN   = (HOLD_CYC != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             we_q, we_nxt;
  logic [2:0]       a_nxt;
  logic             ack_nxt, miss_nxt;
  logic             hit;
  logic             unused_addr;

  assign hit         = (addr[ADDR_W-1:WIN_LSB] == WIN_W'(WIN_BASE));
  assign unused_addr = ^addr;

  // State, phase counter and latched direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      we_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      we_q  <= we_nxt;
    end
  end

  // Next-state, counter and ack/miss/select decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_nxt    = we_q;
    a_nxt     = dec_a;
    ack_nxt   = 1'b0;
    miss_nxt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            state_nxt = S_SETUP;
            cnt_nxt   = SETUP_LD;
            we_nxt    = we;
            a_nxt     = addr[SEL_LSB+2:SEL_LSB];
          end else begin
            ack_nxt  = 1'b1;
            miss_nxt = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_nxt = S_STROBE;
          cnt_nxt   = STROBE_LD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt == '0) begin
          if (HOLD_EN) begin
            state_nxt = S_HOLD;
            cnt_nxt   = HOLD_LD;
          end else begin
            state_nxt = S_IDLE;
            ack_nxt   = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
          ack_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Decoder-facing outputs registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      ack       <= 1'b0;
      miss      <= 1'b0;
      dec_a     <= 3'b000;
      dec_g1    <= 1'b0;
      dec_g2a_n <= 1'b1;
      dec_g2b_n <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
    end else begin
      busy      <= (state_nxt != S_IDLE);
      ack       <= ack_nxt;
      miss      <= miss_nxt;
      dec_a     <= a_nxt;
      dec_g1    <= (state_nxt != S_IDLE);
      dec_g2a_n <= (state_nxt != S_STROBE);
      dec_g2b_n <= (state_nxt == S_IDLE);
      rd_n      <= !((state_nxt == S_STROBE) && !we_nxt);
      wr_n      <= !((state_nxt == S_STROBE) && we_nxt);
    end
  end

endmodule

// File: doc/io_strobe_seq.md
# io_strobe_seq

Bus-cycle sequencer that sits directly upstream of the 3-to-8 I/O chip-select decoder. It accepts one CPU I/O request at a time and checks the address against the decoded I/O window. It then drives the decoder's select (A[2:0]) and enable (G1, G2A_n, G2B_n) inputs through setup, strobe and hold phases, so the decoder output is asserted only during the strobe phase. All decoder-facing outputs are registered, so the decoder never sees combinational glitches from the CPU address bus.

## Interface
Parameters:
- ADDR_W, 16, CPU address width
- WIN_LSB, 11, lowest address bit of the window compare
- WIN_BASE, 5'h0B, required value of addr[ADDR_W-1:WIN_LSB] (window 16'h5800–16'h5FFF at defaults)
- SEL_LSB, 8, decoder select = addr[SEL_LSB+2:SEL_LSB]
- SETUP_CYC, 1, setup-phase cycles, legal 1..15
- STROBE_CYC, 2, strobe-phase cycles, legal 1..15
- HOLD_CYC, 1, hold-phase cycles, legal 0..15 (0 skips HOLD)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req  in  1  request; sampled only when busy=0
- we  in  1  1=write, 0=read; sampled with req
- addr  in  ADDR_W  request address; sampled with req
- busy  out  1  transaction in progress (SETUP/STROBE/HOLD)
- ack  out  1  one-cycle completion pulse
- miss  out  1  qualifies ack: address outside window, no strobe issued
- dec_a  out  3  decoder select
- dec_g1  out  1  decoder G1 (active-high enable)
- dec_g2a_n  out  1  decoder G2A (active-low), strobe qualifier
- dec_g2b_n  out  1  decoder G2B (active-low), cycle qualifier
- rd_n  out  1  active-low read strobe to I/O devices
- wr_n  out  1  active-low write strobe to I/O devices

## Operation
- States: IDLE, SETUP, STROBE, HOLD. A 4-bit phase counter loads N-1 on entry to each phase and advances the state when it reaches 0.
- IDLE with req=1 and window hit:
  - latch dec_a and we;
  - set dec_g1=1 and dec_g2b_n=0;
  - go to SETUP.
- IDLE with req=1 and window miss:
  - next cycle ack=1 and miss=1;
  - stay in IDLE; busy, dec_g1 and the strobes do not move.
- SETUP for SETUP_CYC cycles, then STROBE.
- STROBE for STROBE_CYC cycles:
  - dec_g2a_n=0;
  - rd_n=0 if the latched we=0, otherwise wr_n=0.
- HOLD for HOLD_CYC cycles, or skipped when HOLD_CYC=0. dec_g2a_n, rd_n and wr_n are back to 1.
- Exit to IDLE: dec_g1=0, dec_g2b_n=1, ack=1 with miss=0 for exactly one cycle.
- dec_a holds the latched value until the next accepted request. It is not cleared on completion.
- req while busy=1 is ignored and not queued. addr and we changes during a transaction have no effect.
- The ack cycle is an IDLE cycle. A req present then is accepted: back-to-back transactions with no dead cycle.
- All outputs come directly from flops.

## Timing
- Reset value of every output:
  - busy=0, ack=0, miss=0;
  - dec_a=3'b000, dec_g1=0, dec_g2a_n=1, dec_g2b_n=1;
  - rd_n=1, wr_n=1.
  - State is IDLE.
- Reset asserted mid-transaction: next cycle, all outputs at reset values. No ack is issued for the aborted transaction. Reset has priority over req.
- Hit with req sampled high in cycle n:
  - busy, dec_g1=1 and dec_g2b_n=0 from cycle n+1;
  - strobe low in cycles n+1+S .. n+S+T;
  - ack high in cycle n+1+S+T+H (S/T/H = SETUP_CYC/STROBE_CYC/HOLD_CYC).
  - Defaults: strobe in n+2..n+3, ack at n+5.
- Miss with req in cycle n: ack=1, miss=1 in cycle n+1 only.
- dec_a and dec_g2b_n are stable for at least SETUP_CYC cycles before dec_g2a_n falls and at least HOLD_CYC cycles after it rises.

## Test plan
- Reset then idle: all outputs at reset values. With req=0 for 20 cycles, busy and ack stay 0.
- Write hit at defaults (req in cycle 0, addr=16'h5A00, we=1):
  - dec_a=3'b010 from cycle 1;
  - wr_n=0 and dec_g2a_n=0 in cycles 2–3;
  - rd_n stays 1;
  - ack=1 and miss=0 in cycle 5 only.
- Read miss (addr=16'h1234, we=0): ack=1 and miss=1 in the next cycle. busy, dec_g1, rd_n and dec_g2a_n never move.
- Back-to-back with parameter edges (SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=0):
  - read 16'h5F00, then req held high with 16'h5800;
  - first ack at cycle 3, where the second request is accepted;
  - second strobe in cycle 5, second ack at cycle 6;
  - req pulses while busy produce no extra transaction.
- Reset mid-strobe: assert reset in the first STROBE cycle. Next cycle all outputs are at reset values and no ack is ever seen. A fresh request afterwards completes normally.
